// File: rtl/wired_axi_pkg.sv
// Shared types for the registered AXI4 pipeline stage on the core memory path.
// Channel payload structs use the package widths (32-bit data, 32-bit address, 4-bit ID).
// Optional feature macro: WIRED_REGSLICE_FULL_EN (two-entry skid buffers, full throughput).
package wired_axi_pkg;

   localparam int unsigned AXI_DATA_WIDTH = 32;
   localparam int unsigned AXI_ADDR_WIDTH = 32;
   localparam int unsigned AXI_ID_WIDTH   = 4;
   localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   // AW and AR share one layout: 49 bits at package widths.
   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic [2:0]                size;
      logic [1:0]                burst;
   } axi_ax_t;

   typedef struct packed {
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [AXI_STRB_WIDTH-1:0] strb;
      logic                      last;
   } axi_w_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0] id;
      logic [1:0]              resp;
   } axi_b_t;

   typedef struct packed {
      logic [AXI_ID_WIDTH-1:0]   id;
      logic [AXI_DATA_WIDTH-1:0] data;
      logic [1:0]                resp;
      logic                      last;
   } axi_r_t;

   // Bit 0 doubles as "main entry valid" so out_valid is a plain flop bit.
   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StOne   = 2'b01,
      StTwo   = 2'b11
   } buf_state_e;

endpackage

// File: rtl/wired_skid_buf.sv
// One-channel registered buffer: every output is driven straight from a flop.
// WIRED_REGSLICE_FULL_EN defined: main + skid entry, one beat per cycle sustained.
// Undefined (default): main entry only, one beat every two cycles.
module wired_skid_buf
   import wired_axi_pkg::*;
#(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o
);

   buf_state_e       state_q, state_d;
   logic             ready_q, ready_d;
   logic [Width-1:0] main_q, main_d;
`ifdef WIRED_REGSLICE_FULL_EN
   logic [Width-1:0] skid_q, skid_d;
`endif
   logic             in_fire;
   logic             out_fire;

   assign in_fire     = in_valid_i & ready_q;
   assign out_fire    = state_q[0] & out_ready_i;
   assign in_ready_o  = ready_q;
   assign out_valid_o = state_q[0];
   assign out_data_o  = main_q;

   // Next state and entry loads; payload registers change only on a handshake.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef WIRED_REGSLICE_FULL_EN
      skid_d  = skid_q;
`endif
      case (state_q)
         StEmpty: begin
            if (in_fire) begin
               state_d = StOne;
               main_d  = in_data_i;
            end
         end
         StOne: begin
`ifdef WIRED_REGSLICE_FULL_EN
            if (in_fire && out_fire) begin
               main_d = in_data_i;
            end else if (in_fire) begin
               state_d = StTwo;
               skid_d  = in_data_i;
            end else if (out_fire) begin
               state_d = StEmpty;
            end
`else
            // Input is not ready here, so only the output can fire.
            if (out_fire) begin
               state_d = StEmpty;
            end
`endif
         end
         StTwo: begin
`ifdef WIRED_REGSLICE_FULL_EN
            if (out_fire) begin
               state_d = StOne;
               main_d  = skid_q;
            end
`else
            state_d = StEmpty;
`endif
         end
         default: state_d = StEmpty;
      endcase
`ifdef WIRED_REGSLICE_FULL_EN
      ready_d = (state_d != StTwo);
`else
      ready_d = (state_d == StEmpty);
`endif
   end

   // State, ready and payload registers; ready stays low for the whole reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         ready_q <= 1'b0;
         main_q  <= '0;
`ifdef WIRED_REGSLICE_FULL_EN
         skid_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         main_q  <= main_d;
`ifdef WIRED_REGSLICE_FULL_EN
         skid_q  <= skid_d;
`endif
      end
   end

endmodule

// File: rtl/wired_axi_regslice.sv
// Registered AXI4 stage between the core mem host port and the SoC interconnect.
// All five channels pass through independent wired_skid_buf instances; this level only
// packs, unpacks and wires. Optional feature macro: WIRED_REGSLICE_FULL_EN.
module wired_axi_regslice
   import wired_axi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int unsigned ID_WIDTH   = AXI_ID_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   // Host (core) side
   input  logic [ID_WIDTH-1:0]     host_awid,
   input  logic [ADDR_WIDTH-1:0]   host_awaddr,
   input  logic [7:0]              host_awlen,
   input  logic [2:0]              host_awsize,
   input  logic [1:0]              host_awburst,
   input  logic                    host_awvalid,
   output logic                    host_awready,
   input  logic [DATA_WIDTH-1:0]   host_wdata,
   input  logic [DATA_WIDTH/8-1:0] host_wstrb,
   input  logic                    host_wlast,
   input  logic                    host_wvalid,
   output logic                    host_wready,
   output logic [ID_WIDTH-1:0]     host_bid,
   output logic [1:0]              host_bresp,
   output logic                    host_bvalid,
   input  logic                    host_bready,
   input  logic [ID_WIDTH-1:0]     host_arid,
   input  logic [ADDR_WIDTH-1:0]   host_araddr,
   input  logic [7:0]              host_arlen,
   input  logic [2:0]              host_arsize,
   input  logic [1:0]              host_arburst,
   input  logic                    host_arvalid,
   output logic                    host_arready,
   output logic [ID_WIDTH-1:0]     host_rid,
   output logic [DATA_WIDTH-1:0]   host_rdata,
   output logic [1:0]              host_rresp,
   output logic                    host_rlast,
   output logic                    host_rvalid,
   input  logic                    host_rready,
   // Interconnect side
   output logic [ID_WIDTH-1:0]     mem_awid,
   output logic [ADDR_WIDTH-1:0]   mem_awaddr,
   output logic [7:0]              mem_awlen,
   output logic [2:0]              mem_awsize,
   output logic [1:0]              mem_awburst,
   output logic                    mem_awvalid,
   input  logic                    mem_awready,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   output logic                    mem_wlast,
   output logic                    mem_wvalid,
   input  logic                    mem_wready,
   input  logic [ID_WIDTH-1:0]     mem_bid,
   input  logic [1:0]              mem_bresp,
   input  logic                    mem_bvalid,
   output logic                    mem_bready,
   output logic [ID_WIDTH-1:0]     mem_arid,
   output logic [ADDR_WIDTH-1:0]   mem_araddr,
   output logic [7:0]              mem_arlen,
   output logic [2:0]              mem_arsize,
   output logic [1:0]              mem_arburst,
   output logic                    mem_arvalid,
   input  logic                    mem_arready,
   input  logic [ID_WIDTH-1:0]     mem_rid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic [1:0]              mem_rresp,
   input  logic                    mem_rlast,
   input  logic                    mem_rvalid,
   output logic                    mem_rready
);

   axi_ax_t aw_in, aw_out, ar_in, ar_out;
   axi_w_t  w_in, w_out;
   axi_b_t  b_in, b_out;
   axi_r_t  r_in, r_out;

   assign aw_in = '{id: host_awid, addr: host_awaddr, len: host_awlen, size: host_awsize,
                    burst: host_awburst};
   assign ar_in = '{id: host_arid, addr: host_araddr, len: host_arlen, size: host_arsize,
                    burst: host_arburst};
   assign w_in  = '{data: host_wdata, strb: host_wstrb, last: host_wlast};
   assign b_in  = '{id: mem_bid, resp: mem_bresp};
   assign r_in  = '{id: mem_rid, data: mem_rdata, resp: mem_rresp, last: mem_rlast};

   assign mem_awid    = aw_out.id;
   assign mem_awaddr  = aw_out.addr;
   assign mem_awlen   = aw_out.len;
   assign mem_awsize  = aw_out.size;
   assign mem_awburst = aw_out.burst;
   assign mem_arid    = ar_out.id;
   assign mem_araddr  = ar_out.addr;
   assign mem_arlen   = ar_out.len;
   assign mem_arsize  = ar_out.size;
   assign mem_arburst = ar_out.burst;
   assign mem_wdata   = w_out.data;
   assign mem_wstrb   = w_out.strb;
   assign mem_wlast   = w_out.last;
   assign host_bid    = b_out.id;
   assign host_bresp  = b_out.resp;
   assign host_rid    = r_out.id;
   assign host_rdata  = r_out.data;
   assign host_rresp  = r_out.resp;
   assign host_rlast  = r_out.last;

   wired_skid_buf #(.Width($bits(axi_ax_t))) u_aw (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (host_awvalid),
      .in_ready_o (host_awready),
      .in_data_i  (aw_in),
      .out_valid_o(mem_awvalid),
      .out_ready_i(mem_awready),
      .out_data_o (aw_out)
   );

   wired_skid_buf #(.Width($bits(axi_w_t))) u_w (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (host_wvalid),
      .in_ready_o (host_wready),
      .in_data_i  (w_in),
      .out_valid_o(mem_wvalid),
      .out_ready_i(mem_wready),
      .out_data_o (w_out)
   );

   wired_skid_buf #(.Width($bits(axi_b_t))) u_b (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (mem_bvalid),
      .in_ready_o (mem_bready),
      .in_data_i  (b_in),
      .out_valid_o(host_bvalid),
      .out_ready_i(host_bready),
      .out_data_o (b_out)
   );

   wired_skid_buf #(.Width($bits(axi_ax_t))) u_ar (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (host_arvalid),
      .in_ready_o (host_arready),
      .in_data_i  (ar_in),
      .out_valid_o(mem_arvalid),
      .out_ready_i(mem_arready),
      .out_data_o (ar_out)
   );

   wired_skid_buf #(.Width($bits(axi_r_t))) u_r (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (mem_rvalid),
      .in_ready_o (mem_rready),
      .in_data_i  (r_in),
      .out_valid_o(host_rvalid),
      .out_ready_i(host_rready),
      .out_data_o (r_out)
   );

endmodule

// File: tb/tb_wired_axi_regslice.sv
// Self-checking bench for wired_axi_regslice. Each channel is modelled as a FIFO of
// accepted beats with capacity 2 (WIRED_REGSLICE_FULL_EN) or 1 (default).
// Channel index: 0 AW, 1 W, 2 AR, 3 B, 4 R.
module tb_wired_axi_regslice;
   import wired_axi_pkg::*;

`ifdef WIRED_REGSLICE_FULL_EN
   localparam int Cap = 2;
`else
   localparam int Cap = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [3:0]  host_awid, host_arid, host_bid, host_rid;
   logic [31:0] host_awaddr, host_araddr, host_wdata, host_rdata;
   logic [7:0]  host_awlen, host_arlen;
   logic [2:0]  host_awsize, host_arsize;
   logic [1:0]  host_awburst, host_arburst, host_bresp, host_rresp;
   logic [3:0]  host_wstrb;
   logic        host_wlast, host_rlast;
   logic        host_awvalid, host_awready, host_wvalid, host_wready, host_bvalid, host_bready;
   logic        host_arvalid, host_arready, host_rvalid, host_rready;
   logic [3:0]  mem_awid, mem_arid, mem_bid, mem_rid;
   logic [31:0] mem_awaddr, mem_araddr, mem_wdata, mem_rdata;
   logic [7:0]  mem_awlen, mem_arlen;
   logic [2:0]  mem_awsize, mem_arsize;
   logic [1:0]  mem_awburst, mem_arburst, mem_bresp, mem_rresp;
   logic [3:0]  mem_wstrb;
   logic        mem_wlast, mem_rlast;
   logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready, mem_bvalid, mem_bready;
   logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;

   // Generic per-channel view: source side (sender) and destination side (receiver).
   logic [63:0] src_pl [5];
   logic        src_vld[5];
   logic        snk_rdy[5];
   logic [63:0] dst_pl [5];
   logic        dst_vld[5];
   logic        src_rdy[5];

   logic [63:0] exp_q[5][$];
   int          pw[5] = '{49, 37, 49, 6, 39};
   bit          in_f[5];
   bit          out_f[5];
   bit          last_rst = 1'b1;
   int          total = 0;
   int          bad = 0;

   assign {host_awid, host_awaddr, host_awlen, host_awsize, host_awburst} = src_pl[0][48:0];
   assign {host_wdata, host_wstrb, host_wlast} = src_pl[1][36:0];
   assign {host_arid, host_araddr, host_arlen, host_arsize, host_arburst} = src_pl[2][48:0];
   assign {mem_bid, mem_bresp} = src_pl[3][5:0];
   assign {mem_rid, mem_rdata, mem_rresp, mem_rlast} = src_pl[4][38:0];
   assign host_awvalid = src_vld[0];
   assign host_wvalid  = src_vld[1];
   assign host_arvalid = src_vld[2];
   assign mem_bvalid   = src_vld[3];
   assign mem_rvalid   = src_vld[4];
   assign mem_awready  = snk_rdy[0];
   assign mem_wready   = snk_rdy[1];
   assign mem_arready  = snk_rdy[2];
   assign host_bready  = snk_rdy[3];
   assign host_rready  = snk_rdy[4];
   assign src_rdy[0] = host_awready;
   assign src_rdy[1] = host_wready;
   assign src_rdy[2] = host_arready;
   assign src_rdy[3] = mem_bready;
   assign src_rdy[4] = mem_rready;
   assign dst_vld[0] = mem_awvalid;
   assign dst_vld[1] = mem_wvalid;
   assign dst_vld[2] = mem_arvalid;
   assign dst_vld[3] = host_bvalid;
   assign dst_vld[4] = host_rvalid;
   assign dst_pl[0] = {15'd0, mem_awid, mem_awaddr, mem_awlen, mem_awsize, mem_awburst};
   assign dst_pl[1] = {27'd0, mem_wdata, mem_wstrb, mem_wlast};
   assign dst_pl[2] = {15'd0, mem_arid, mem_araddr, mem_arlen, mem_arsize, mem_arburst};
   assign dst_pl[3] = {58'd0, host_bid, host_bresp};
   assign dst_pl[4] = {25'd0, host_rid, host_rdata, host_rresp, host_rlast};

   wired_axi_regslice dut (
      .clk(clk), .rst(rst),
      .host_awid(host_awid), .host_awaddr(host_awaddr), .host_awlen(host_awlen),
      .host_awsize(host_awsize), .host_awburst(host_awburst), .host_awvalid(host_awvalid),
      .host_awready(host_awready),
      .host_wdata(host_wdata), .host_wstrb(host_wstrb), .host_wlast(host_wlast),
      .host_wvalid(host_wvalid), .host_wready(host_wready),
      .host_bid(host_bid), .host_bresp(host_bresp), .host_bvalid(host_bvalid),
      .host_bready(host_bready),
      .host_arid(host_arid), .host_araddr(host_araddr), .host_arlen(host_arlen),
      .host_arsize(host_arsize), .host_arburst(host_arburst), .host_arvalid(host_arvalid),
      .host_arready(host_arready),
      .host_rid(host_rid), .host_rdata(host_rdata), .host_rresp(host_rresp),
      .host_rlast(host_rlast), .host_rvalid(host_rvalid), .host_rready(host_rready),
      .mem_awid(mem_awid), .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen),
      .mem_awsize(mem_awsize), .mem_awburst(mem_awburst), .mem_awvalid(mem_awvalid),
      .mem_awready(mem_awready),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
      .mem_bid(mem_bid), .mem_bresp(mem_bresp), .mem_bvalid(mem_bvalid),
      .mem_bready(mem_bready),
      .mem_arid(mem_arid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen),
      .mem_arsize(mem_arsize), .mem_arburst(mem_arburst), .mem_arvalid(mem_arvalid),
      .mem_arready(mem_arready),
      .mem_rid(mem_rid), .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
      .mem_rlast(mem_rlast), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rnd_pl(input int ch);
      logic [63:0] v;
      v = {$urandom, $urandom};
      v = v & ((64'd1 << pw[ch]) - 64'd1);
      if (ch == 3) v = {58'd0, v[5:2], AXI_RESP_OKAY};
      return v;
   endfunction

   // Check all channels against the FIFO model, then advance one clock and update it.
   task automatic step();
      for (int ch = 0; ch < 5; ch++) begin
         check($sformatf("valid_ch%0d", ch), 64'(dst_vld[ch]), 64'(exp_q[ch].size() != 0));
         check($sformatf("ready_ch%0d", ch), 64'(src_rdy[ch]),
               64'(!last_rst && (exp_q[ch].size() < Cap)));
         if (dst_vld[ch] && exp_q[ch].size() != 0)
            check($sformatf("payload_ch%0d", ch), dst_pl[ch], exp_q[ch][0]);
         in_f[ch]  = src_vld[ch] && src_rdy[ch];
         out_f[ch] = dst_vld[ch] && snk_rdy[ch];
      end
      @(posedge clk);
      last_rst = rst;
      for (int ch = 0; ch < 5; ch++) begin
         if (rst) begin
            exp_q[ch].delete();
         end else begin
            if (out_f[ch] && exp_q[ch].size() != 0) void'(exp_q[ch].pop_front());
            if (in_f[ch]) exp_q[ch].push_back(src_pl[ch]);
         end
      end
      #1;
   endtask

   task automatic idle_all(input int cycles);
      for (int ch = 0; ch < 5; ch++) begin
         src_vld[ch] = 1'b0;
         snk_rdy[ch] = 1'b1;
      end
      for (int n = 0; n < cycles; n++) step();
   endtask

   initial begin
      int idx, first, lastc, nout, sent, got;
      for (int ch = 0; ch < 5; ch++) begin
         src_pl[ch]  = '0;
         src_vld[ch] = 1'b0;
         snk_rdy[ch] = 1'b0;
      end

      // Reset with AW valid held high.
      src_vld[0] = 1'b1;
      src_pl[0]  = rnd_pl(0);
      @(posedge clk);
      #1;
      repeat (3) step();
      check("rst_awready", 64'(host_awready), 64'd0);
      check("rst_mem_awvalid", 64'(mem_awvalid), 64'd0);
      rst = 1'b0;
      src_vld[0] = 1'b0;
      step();
      check("awready_after_rst", 64'(host_awready), 64'd1);

      // Single AR.
      src_pl[2]  = {15'd0, 4'd5, 32'h8000_0040, 8'd3, 3'd2, 2'd1};
      src_vld[2] = 1'b1;
      check("ar_ready_before", 64'(host_arready), 64'd1);
      step();
      src_vld[2] = 1'b0;
      check("ar_valid_lat1", 64'(mem_arvalid), 64'd1);
      check("ar_id", 64'(mem_arid), 64'd5);
      check("ar_addr", 64'(mem_araddr), 64'h8000_0040);
      check("ar_len", 64'(mem_arlen), 64'd3);
      snk_rdy[2] = 1'b1;
      step();
      check("ar_empty_after", 64'(mem_arvalid), 64'd0);

      // W burst of 4 beats, sink always ready.
      idle_all(2);
      idx = 0; first = -1; lastc = -1; nout = 0;
      for (int n = 0; n < 20; n++) begin
         if (idx < 4) begin
            src_vld[1] = 1'b1;
            src_pl[1]  = {27'd0, 32'(32'h1111_1111 * (idx + 1)), 4'hf, 1'(idx == 3)};
         end else begin
            src_vld[1] = 1'b0;
         end
         step();
         if (in_f[1]) idx++;
         if (out_f[1]) begin
            if (first < 0) first = n;
            lastc = n;
            nout++;
         end
      end
      check("w_beats", 64'(nout), 64'd4);
      check("w_span", 64'(lastc - first), (Cap == 2) ? 64'd3 : 64'd6);

      // R stream stalled at the host for 5 cycles.
      idle_all(2);
      snk_rdy[4] = 1'b0;
      src_vld[4] = 1'b1;
      src_pl[4]  = rnd_pl(4);
      sent = 0; got = 0;
      for (int n = 0; n < 5; n++) begin
         step();
         if (in_f[4]) begin
            sent++;
            src_pl[4] = rnd_pl(4);
         end
         if (out_f[4]) got++;
      end
      check("r_stall_accepted", 64'(sent), 64'(Cap));
      check("r_stall_rready", 64'(mem_rready), 64'd0);
      snk_rdy[4] = 1'b1;
      for (int n = 0; n < 30; n++) begin
         if (sent >= 6) src_vld[4] = 1'b0;
         step();
         if (in_f[4]) begin
            sent++;
            src_pl[4] = rnd_pl(4);
         end
         if (out_f[4]) got++;
      end
      check("r_delivered", 64'(got), 64'd6);

      // Random valid/ready on all channels.
      idle_all(2);
      for (int n = 0; n < 10000; n++) begin
         for (int ch = 0; ch < 5; ch++) begin
            if (!src_vld[ch] || in_f[ch]) begin
               src_vld[ch] = ($urandom_range(0, 3) != 0);
               src_pl[ch]  = rnd_pl(ch);
            end
            snk_rdy[ch] = (n < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
         end
         step();
      end
      idle_all(8);
      for (int ch = 0; ch < 5; ch++)
         check($sformatf("drained_ch%0d", ch), 64'(exp_q[ch].size()), 64'd0);

      // Fill AW, then reset with beats still buffered.
      snk_rdy[0] = 1'b0;
      src_vld[0] = 1'b1;
      src_pl[0]  = rnd_pl(0);
      for (int n = 0; n < 3; n++) begin
         step();
         if (in_f[0]) src_pl[0] = rnd_pl(0);
      end
      check("aw_full_before_rst", 64'(exp_q[0].size()), 64'(Cap));
      for (int ch = 0; ch < 5; ch++) src_vld[ch] = 1'b0;
      rst = 1'b1;
      step();
      check("aw_valid_in_rst", 64'(mem_awvalid), 64'd0);
      rst = 1'b0;
      snk_rdy[0] = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         check("aw_no_stale", 64'(mem_awvalid), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
